// File: rtl/read_return_mux_pkg.sv
// Shared bus definitions for the read/write return muxes: FSM state and
// target encodings.
package read_return_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_MEM  = 2'd1,
    ST_WAIT_UART = 2'd2,
    ST_DONE      = 2'd3
  } rd_state_e;

  typedef enum logic {
    TGT_MEM  = 1'b0,
    TGT_UART = 1'b1
  } tgt_e;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/read_return_mux_wait_timer.sv
// Per-read wait counter: counts enabled cycles and flags the final
// cycle before the limit is reached.
module read_return_mux_wait_timer
  import read_return_mux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The last allowed wait cycle is the one where the count reads limit-1.
  assign expired_o = (count_q == (limit_i - 16'd1));

endmodule

// File: rtl/read_return_mux.sv
// Returns read data from memory or UART to the CPU, stalling it while the
// selected target answers and forcing completion after a timeout.
module read_return_mux
  import read_return_mux_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        read,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,
  input  logic [7:0]  uart_rd_data,
  input  logic        uart_rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        stall,
  output logic        timeout_err,
  output logic        stray_err,
  output rd_state_e   dbg_state
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  rd_state_e   state_q;
  tgt_e        tgt_q;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;
  logic        timeout_err_q;
  logic        stray_err_q;

  logic waiting;
  logic match_valid;
  logic other_valid;
  logic any_valid;
  logic expired;

  assign waiting     = (state_q == ST_WAIT_MEM) || (state_q == ST_WAIT_UART);
  assign match_valid = (tgt_q == TGT_UART) ? uart_rd_valid : mem_rd_valid;
  assign other_valid = (tgt_q == TGT_UART) ? mem_rd_valid  : uart_rd_valid;
  assign any_valid   = mem_rd_valid || uart_rd_valid;

  read_return_mux_wait_timer u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (waiting && !match_valid),
    .clr_i     ((state_q == ST_IDLE) && read),
    .limit_i   (LIMIT),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      tgt_q         <= TGT_MEM;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      stray_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_valid) stray_err_q <= 1'b1;
          if (read) begin
            tgt_q   <= tgt_e'(sel);
            state_q <= sel ? ST_WAIT_UART : ST_WAIT_MEM;
          end
        end
        ST_WAIT_MEM, ST_WAIT_UART: begin
          if (other_valid) stray_err_q <= 1'b1;
          // A matching valid beats a timeout landing in the same cycle.
          if (match_valid) begin
            rd_data_q  <= (tgt_q == TGT_UART) ? {24'h0, uart_rd_data} : mem_rd_data;
            rd_valid_q <= 1'b1;
            state_q    <= ST_DONE;
          end else if (expired) begin
            rd_data_q     <= TIMEOUT_DATA;
            timeout_err_q <= 1'b1;
            rd_valid_q    <= 1'b1;
            state_q       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (any_valid) stray_err_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall       = ((state_q == ST_IDLE) && read) || waiting;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign timeout_err = timeout_err_q;
  assign stray_err   = stray_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_read_return_mux.sv
// Directed bench for read_return_mux: memory/UART reads, wrong-target
// valids, timeout and its race, reset mid-read and back-to-back reads.
module tb_read_return_mux;
  import read_return_mux_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        read;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [7:0]  uart_rd_data;
  logic        uart_rd_valid;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        stall;
  logic        timeout_err;
  logic        stray_err;
  rd_state_e   dbg_state;

  int n_vec;
  int n_err;

  read_return_mux #(
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_DATA   (32'hFFFF_FFFF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel           (sel),
    .read          (read),
    .mem_rd_data   (mem_rd_data),
    .mem_rd_valid  (mem_rd_valid),
    .uart_rd_data  (uart_rd_data),
    .uart_rd_valid (uart_rd_valid),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .stall         (stall),
    .timeout_err   (timeout_err),
    .stray_err     (stray_err),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: move past the rising edge, apply inputs, settle at the falling edge.
  task automatic drive(input logic rd, input logic s, input logic mv, input logic [31:0] md,
                       input logic uv, input logic [7:0] ud);
    @(posedge clk);
    #1;
    read          = rd;
    sel           = s;
    mem_rd_valid  = mv;
    mem_rd_data   = md;
    uart_rd_valid = uv;
    uart_rd_data  = ud;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    read = 1'b0; sel = 1'b0; mem_rd_valid = 1'b0; uart_rd_valid = 1'b0;
    mem_rd_data = '0; uart_rd_data = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset values, and stall following read while in reset
    rst_n = 1'b0;
    read = 1'b0; sel = 1'b0; mem_rd_valid = 1'b0; uart_rd_valid = 1'b0;
    mem_rd_data = '0; uart_rd_data = '0;
    #2;
    check_eq("rst_rd_data", rd_data, 32'h0);
    check_eq("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check_eq("rst_timeout_err", {31'h0, timeout_err}, 32'h0);
    check_eq("rst_stray_err", {31'h0, stray_err}, 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("rst_stall_idle", {31'h0, stall}, 32'h0);
    read = 1'b1;
    #1;
    check_eq("rst_stall_read", {31'h0, stall}, 32'h1);
    do_reset();

    // Memory read, valid two cycles after the request
    drive(1, 0, 0, 32'h0, 0, 8'h0);
    check_eq("mem_stall_n", {31'h0, stall}, 32'h1);
    drive(1, 0, 0, 32'h0, 0, 8'h0);
    check_eq("mem_state_wait", 32'(dbg_state), 32'(ST_WAIT_MEM));
    check_eq("mem_stall_n1", {31'h0, stall}, 32'h1);
    drive(1, 0, 1, 32'h1234_5678, 0, 8'h0);
    check_eq("mem_stall_n2", {31'h0, stall}, 32'h1);
    check_eq("mem_no_valid_yet", {31'h0, rd_valid}, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 8'h0);
    check_eq("mem_rd_valid", {31'h0, rd_valid}, 32'h1);
    check_eq("mem_rd_data", rd_data, 32'h1234_5678);
    check_eq("mem_stall_done", {31'h0, stall}, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 8'h0);
    check_eq("mem_valid_pulse", {31'h0, rd_valid}, 32'h0);
    check_eq("mem_data_hold", rd_data, 32'h1234_5678);
    check_eq("mem_state_idle", 32'(dbg_state), 32'(ST_IDLE));

    // UART read; sel flipping during the wait must be ignored
    drive(1, 1, 0, 32'h0, 0, 8'h0);
    drive(1, 0, 0, 32'h0, 1, 8'hA5);
    check_eq("uart_state_wait", 32'(dbg_state), 32'(ST_WAIT_UART));
    drive(0, 0, 0, 32'h0, 0, 8'h0);
    check_eq("uart_rd_valid", {31'h0, rd_valid}, 32'h1);
    check_eq("uart_rd_data", rd_data, 32'h0000_00A5);
    check_eq("uart_no_stray", {31'h0, stray_err}, 32'h0);

    // Wrong target: memory valid during a UART read
    drive(1, 1, 0, 32'h0, 0, 8'h0);
    drive(1, 1, 1, 32'hDEAD_BEEF, 0, 8'h0);
    drive(1, 1, 0, 32'h0, 1, 8'h3C);
    check_eq("wrong_stray", {31'h0, stray_err}, 32'h1);
    check_eq("wrong_stall", {31'h0, stall}, 32'h1);
    check_eq("wrong_no_valid", {31'h0, rd_valid}, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 8'h0);
    check_eq("wrong_rd_valid", {31'h0, rd_valid}, 32'h1);
    check_eq("wrong_rd_data", rd_data, 32'h0000_003C);

    // Timeout after four silent wait cycles
    drive(1, 0, 0, 32'h0, 0, 8'h0);
    check_eq("to_err_before", {31'h0, timeout_err}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 32'h0, 0, 8'h0);
      check_eq("to_wait_stall", {31'h0, stall}, 32'h1);
      check_eq("to_wait_novalid", {31'h0, rd_valid}, 32'h0);
    end
    drive(0, 0, 0, 32'h0, 0, 8'h0);
    check_eq("to_rd_valid", {31'h0, rd_valid}, 32'h1);
    check_eq("to_rd_data", rd_data, 32'hFFFF_FFFF);
    check_eq("to_err", {31'h0, timeout_err}, 32'h1);
    drive(0, 0, 0, 32'h0, 0, 8'h0);
    check_eq("to_err_sticky", {31'h0, timeout_err}, 32'h1);

    // Matching valid in the timeout cycle wins
    do_reset();
    drive(1, 0, 0, 32'h0, 0, 8'h0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 32'h0, 0, 8'h0);
    drive(1, 0, 1, 32'hCAFE_0001, 0, 8'h0);
    drive(0, 0, 0, 32'h0, 0, 8'h0);
    check_eq("race_rd_valid", {31'h0, rd_valid}, 32'h1);
    check_eq("race_rd_data", rd_data, 32'hCAFE_0001);
    check_eq("race_no_to_err", {31'h0, timeout_err}, 32'h0);

    // Reset in WAIT_MEM abandons the read; the late valid is stray
    drive(1, 0, 0, 32'h0, 0, 8'h0);
    drive(1, 0, 0, 32'h0, 0, 8'h0);
    check_eq("rstw_state_wait", 32'(dbg_state), 32'(ST_WAIT_MEM));
    rst_n = 1'b0;
    #1;
    check_eq("rstw_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("rstw_data_clear", rd_data, 32'h0);
    read = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 1, 32'h5555_AAAA, 0, 8'h0);
    drive(0, 0, 0, 32'h0, 0, 8'h0);
    check_eq("rstw_stray", {31'h0, stray_err}, 32'h1);
    check_eq("rstw_no_valid", {31'h0, rd_valid}, 32'h0);
    check_eq("rstw_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Back-to-back: read held through DONE, next read right after
    drive(1, 0, 0, 32'h0, 0, 8'h0);
    drive(1, 0, 1, 32'h1111_2222, 0, 8'h0);
    drive(1, 0, 0, 32'h0, 0, 8'h0);
    check_eq("b2b_valid1", {31'h0, rd_valid}, 32'h1);
    check_eq("b2b_data1", rd_data, 32'h1111_2222);
    check_eq("b2b_state_done", 32'(dbg_state), 32'(ST_DONE));
    drive(1, 1, 0, 32'h0, 0, 8'h0);
    check_eq("b2b_gap_valid", {31'h0, rd_valid}, 32'h0);
    check_eq("b2b_stall2", {31'h0, stall}, 32'h1);
    drive(1, 1, 0, 32'h0, 1, 8'h77);
    check_eq("b2b_wait_valid", {31'h0, rd_valid}, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 8'h0);
    check_eq("b2b_valid2", {31'h0, rd_valid}, 32'h1);
    check_eq("b2b_data2", rd_data, 32'h0000_0077);
    drive(0, 0, 0, 32'h0, 0, 8'h0);
    check_eq("b2b_end_valid", {31'h0, rd_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/read_return_mux.md
READ_RETURN_MUX -- requirements
Module: read_return_mux

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max wait cycles per read before forced completion (1..65535).
REQ-002 Parameter TIMEOUT_DATA, default 32'hFFFF_FFFF, data returned on timeout.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sel  input  1  target select at request time: 1 = UART, 0 = memory.
REQ-006 read  input  1  CPU read request, held high by the CPU while stall is high.
REQ-007 mem_rd_data  input  32  memory read data.
REQ-008 mem_rd_valid  input  1  memory read data valid, one-cycle pulse.
REQ-009 uart_rd_data  input  8  UART read data.
REQ-010 uart_rd_valid  input  1  UART read data valid, one-cycle pulse.
REQ-011 rd_data  output  32  registered read data returned to the CPU.
REQ-012 rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-013 stall  output  1  CPU stall for the read in flight.
REQ-014 timeout_err  output  1  sticky: a read ended by timeout.
REQ-015 stray_err  output  1  sticky: a valid pulse arrived with no matching read outstanding.

Function
REQ-016 FSM states: IDLE, WAIT_MEM, WAIT_UART, DONE.
REQ-017 IDLE: read=1 -> latch sel into target register, clear wait counter, go to WAIT_UART if sel=1, else WAIT_MEM.
REQ-018 WAIT_MEM: mem_rd_valid=1 -> rd_data <= mem_rd_data, go to DONE.
REQ-019 WAIT_UART: uart_rd_valid=1 -> rd_data <= {24'h0, uart_rd_data}, go to DONE.
REQ-020 In WAIT states, the valid of the non-latched target is ignored for data and sets stray_err.
REQ-021 Changes on sel during a WAIT state have no effect; the latched target governs.
REQ-022 Wait counter, 16 bits, increments each WAIT cycle without a matching valid.
REQ-023 Counter = TIMEOUT_CYCLES-1 with no matching valid -> rd_data <= TIMEOUT_DATA, set timeout_err, go to DONE.
REQ-024 Matching valid in the timeout cycle wins: real data is returned, timeout_err unchanged.
REQ-025 DONE: rd_valid=1 for exactly one cycle, then IDLE unconditionally; read is ignored in DONE because it is the completing request.
REQ-026 stall = (state==IDLE && read) || state==WAIT_MEM || state==WAIT_UART; stall is 0 in DONE.
REQ-027 Minimum latency: request in cycle N, valid in cycle N+1, rd_valid in N+2.
REQ-028 Any valid pulse in IDLE or DONE sets stray_err; it is otherwise ignored.
REQ-029 rd_data holds its value outside DONE until the next capture.
REQ-030 Sticky flags clear only on reset.

Reset
REQ-031 rst_n low -> state IDLE, rd_data 0, rd_valid 0, counter 0, target 0, timeout_err 0, stray_err 0, immediately and without a clock.
REQ-032 While rst_n is low, stall depends only on read (state is IDLE).
REQ-033 Reset asserted mid-WAIT abandons the read: no rd_valid is produced, and a later valid for it sets stray_err.
REQ-034 Reset deassertion is synchronised externally; the block needs no internal synchroniser.

Structure
REQ-035 The FSM state encoding and the target encoding (TGT_MEM=0, TGT_UART=1) belong in the shared bus package, common with the write-side mux.
REQ-036 Single module; the timeout counter may be split out as sub-module wait_timer (enable, clear, limit, expired).

Verification
REQ-037 Memory read: sel=0, read=1, mem_rd_valid with 32'h1234_5678 two cycles later -> stall high 3 cycles, rd_valid 1 cycle, rd_data=32'h1234_5678.
REQ-038 UART read: sel=1, uart_rd_data=8'hA5 -> rd_data=32'h0000_00A5, no stray_err.
REQ-039 Wrong target: sel=1, only mem_rd_valid arrives -> stray_err=1, stall remains high until uart_rd_valid arrives.
REQ-040 Timeout: TIMEOUT_CYCLES=4, no valid -> rd_valid after 4 WAIT cycles, rd_data=32'hFFFF_FFFF, timeout_err=1.
REQ-041 Reset in WAIT_MEM, then mem_rd_valid -> no rd_valid, stray_err=1, state IDLE.
REQ-042 Back-to-back: read held through DONE, new read in the following cycle -> exactly two rd_valid pulses with correct data each.
